// File: rtl/core_mem_pkg.sv
// Shared types for the core memory arbiter: requester IDs and arbiter FSM states.
package core_mem_pkg;

  typedef enum logic {
    ARB_INSTR = 1'b0,
    ARB_DATA  = 1'b1
  } arb_id_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic arb_id_t other_id(input arb_id_t id);
    return (id == ARB_INSTR) ? ARB_DATA : ARB_INSTR;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// Response-ID FIFO: remembers which requester owns each outstanding memory transfer.
module arb_id_fifo
  import core_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  arb_id_t data,
  output arb_id_t head,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  arb_id_t          slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= data;
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Two-requester (instr/data) memory arbiter with in-order response routing.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise data has fixed priority.
module core_mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  arb_state_t state;
  arb_id_t    locked_sel;
  arb_id_t    sel;
  arb_id_t    fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       sel_req;
  logic       can_issue;
  logic       grant;
  logic       pop;

`ifdef MEM_ARB_RR_EN
  arb_id_t rr_ptr;

  // rr_ptr names the requester that wins the next tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= ARB_INSTR;
    end else if (grant) begin
      rr_ptr <= other_id(sel);
    end
  end
`endif

  always_comb begin
    sel = ARB_INSTR;
    if (state == LOCKED) begin
      sel = locked_sel;
    end else if (instr_req_i && data_req_i) begin
`ifdef MEM_ARB_RR_EN
      sel = rr_ptr;
`else
      sel = ARB_DATA;
`endif
    end else if (data_req_i) begin
      sel = ARB_DATA;
    end
  end

  assign sel_req   = (sel == ARB_DATA) ? data_req_i : instr_req_i;
  assign pop       = mem_rvalid_i && !fifo_empty;
  assign can_issue = !fifo_full || pop;
  assign mem_req_o = !rst_i && sel_req && can_issue;
  assign grant     = mem_req_o && mem_gnt_i;

  assign mem_addr_o  = (sel == ARB_DATA) ? data_addr_i  : instr_addr_i;
  assign mem_we_o    = (sel == ARB_DATA) ? data_we_i    : 1'b0;
  assign mem_be_o    = (sel == ARB_DATA) ? data_be_i    : '1;
  assign mem_wdata_o = (sel == ARB_DATA) ? data_wdata_i : '0;

  assign instr_gnt_o = grant && (sel == ARB_INSTR);
  assign data_gnt_o  = grant && (sel == ARB_DATA);

  assign instr_rvalid_o = pop && (fifo_head == ARB_INSTR);
  assign data_rvalid_o  = pop && (fifo_head == ARB_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  // Stay LOCKED on an ungranted request so the address cannot switch under the memory.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      locked_sel <= ARB_INSTR;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req_o && !mem_gnt_i) begin
            state      <= LOCKED;
            locked_sel <= sel;
          end
        end
        LOCKED: begin
          if (grant || !sel_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  arb_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk  (clk_i),
    .rst  (rst_i),
    .push (grant),
    .pop  (pop),
    .data (sel),
    .head (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // A response with nothing outstanding has no owner and is dropped.
  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
    !(mem_rvalid_i && fifo_empty));

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed self-checking bench for core_mem_arbiter (default parameters).
module tb_core_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_i;
  logic [63:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [63:0] instr_rdata_o;
  logic        data_req_i;
  logic [63:0] data_addr_i;
  logic        data_we_i;
  logic [7:0]  data_be_i;
  logic [63:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [63:0] data_rdata_o;
  logic        mem_req_o;
  logic [63:0] mem_addr_o;
  logic        mem_we_o;
  logic [7:0]  mem_be_o;
  logic [63:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  core_mem_arbiter dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .instr_req_i   (instr_req_i),
    .instr_addr_i  (instr_addr_i),
    .instr_gnt_o   (instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o (instr_rdata_o),
    .data_req_i    (data_req_i),
    .data_addr_i   (data_addr_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_wdata_i  (data_wdata_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_we_o      (mem_we_o),
    .mem_be_o      (mem_be_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs settle before the next rising edge.
  task automatic applyStimulus(input logic ireq, input logic [63:0] iaddr,
                               input logic dreq, input logic [63:0] daddr,
                               input logic we, input logic [7:0] be, input logic [63:0] wdata,
                               input logic gnt, input logic rvalid, input logic [63:0] rdata);
    @(negedge clk_i);
    instr_req_i  = ireq;
    instr_addr_i = iaddr;
    data_req_i   = dreq;
    data_addr_i  = daddr;
    data_we_i    = we;
    data_be_i    = be;
    data_wdata_i = wdata;
    mem_gnt_i    = gnt;
    mem_rvalid_i = rvalid;
    mem_rdata_i  = rdata;
    #4;
  endtask

  task automatic applyReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  logic exp_d [4];

  initial begin
    rst_i = 1'b1;
    applyStimulus(1, 64'h8000_0000, 1, 64'hD000, 0, 8'hFF, 0, 1, 0, 0);
    checkOutput("reset_mem_req", mem_req_o, 0);
    checkOutput("reset_instr_gnt", instr_gnt_o, 0);
    checkOutput("reset_data_gnt", data_gnt_o, 0);
    checkOutput("reset_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
    applyReset();

    // Instruction fetch, response one cycle later.
    applyStimulus(1, 64'h8000_0000, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("if_mem_req", mem_req_o, 1);
    checkOutput("if_addr", mem_addr_o, 64'h8000_0000);
    checkOutput("if_we", mem_we_o, 0);
    checkOutput("if_be", mem_be_o, 8'hFF);
    checkOutput("if_gnts", {instr_gnt_o, data_gnt_o}, 2'b10);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h1234);
    checkOutput("if_rvalids", {instr_rvalid_o, data_rvalid_o}, 2'b10);
    checkOutput("if_rdata", instr_rdata_o, 64'h1234);

    // Both requesters tie for four cycles.
`ifdef MEM_ARB_RR_EN
    exp_d = '{0, 1, 0, 1};
`else
    exp_d = '{1, 1, 1, 1};
`endif
    applyReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 64'h100, 1, 64'h200, 0, 8'hFF, 0, 1, (i > 0), 64'hA0 + 64'(i));
      checkOutput($sformatf("tie_gnt%0d", i), {instr_gnt_o, data_gnt_o}, {~exp_d[i], exp_d[i]});
      checkOutput($sformatf("tie_addr%0d", i), mem_addr_o, exp_d[i] ? 64'h200 : 64'h100);
      if (i > 0)
        checkOutput($sformatf("tie_rv%0d", i), {instr_rvalid_o, data_rvalid_o}, {~exp_d[i-1], exp_d[i-1]});
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("tie_rv_last", {instr_rvalid_o, data_rvalid_o}, {~exp_d[3], exp_d[3]});

    // Data held ungranted while instr arrives.
    applyReset();
    applyStimulus(0, 64'h1000, 1, 64'hD000, 0, 8'hFF, 0, 0, 0, 0);
    checkOutput("hold_d_addr0", mem_addr_o, 64'hD000);
    for (int i = 1; i < 3; i++) begin
      applyStimulus(1, 64'h1000, 1, 64'hD000, 0, 8'hFF, 0, 0, 0, 0);
      checkOutput($sformatf("hold_d_addr%0d", i), mem_addr_o, 64'hD000);
      checkOutput($sformatf("hold_d_gnt%0d", i), {instr_gnt_o, data_gnt_o}, 2'b00);
    end
    applyStimulus(1, 64'h1000, 1, 64'hD000, 0, 8'hFF, 0, 1, 0, 0);
    checkOutput("hold_d_granted", {instr_gnt_o, data_gnt_o}, 2'b01);
    checkOutput("hold_d_addr3", mem_addr_o, 64'hD000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("hold_d_rv", {instr_rvalid_o, data_rvalid_o}, 2'b01);

    // Instr held ungranted while data arrives.
    applyStimulus(1, 64'h2000, 0, 64'hD000, 0, 8'hFF, 0, 0, 0, 0);
    checkOutput("hold_i_addr0", mem_addr_o, 64'h2000);
    applyStimulus(1, 64'h2000, 1, 64'hD000, 0, 8'hFF, 0, 0, 0, 0);
    checkOutput("hold_i_addr1", mem_addr_o, 64'h2000);
    applyStimulus(1, 64'h2000, 1, 64'hD000, 0, 8'hFF, 0, 1, 0, 0);
    checkOutput("hold_i_granted", {instr_gnt_o, data_gnt_o}, 2'b10);
    checkOutput("hold_i_addr2", mem_addr_o, 64'h2000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("hold_i_rv", {instr_rvalid_o, data_rvalid_o}, 2'b10);

    // FIFO full after two grants; a same-cycle pop lets the third through.
    applyReset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 64'h3000, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput($sformatf("full_gnt%0d", i), instr_gnt_o, 1);
    end
    applyStimulus(1, 64'h3000, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("full_blocked_req", mem_req_o, 0);
    checkOutput("full_blocked_gnt", instr_gnt_o, 0);
    applyStimulus(1, 64'h3000, 0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("full_pop_req", mem_req_o, 1);
    checkOutput("full_pop_gnt", instr_gnt_o, 1);
    checkOutput("full_pop_rv", instr_rvalid_o, 1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput($sformatf("full_drain%0d", i), {instr_rvalid_o, data_rvalid_o}, 2'b10);
    end

    // Partial-byte data write.
    applyStimulus(0, 0, 1, 64'h40, 1, 8'h0F, 64'hCAFE, 1, 0, 0);
    checkOutput("wr_we", mem_we_o, 1);
    checkOutput("wr_be", mem_be_o, 8'h0F);
    checkOutput("wr_wdata", mem_wdata_o, 64'hCAFE);
    checkOutput("wr_gnt", {instr_gnt_o, data_gnt_o}, 2'b01);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h55);
    checkOutput("wr_rv", {instr_rvalid_o, data_rvalid_o}, 2'b01);
    checkOutput("wr_rdata", data_rdata_o, 64'h55);

    // Reset with two transfers outstanding discards them.
    applyStimulus(1, 64'h4000, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 64'h5000, 0, 8'hFF, 0, 1, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    applyStimulus(1, 64'h4000, 1, 64'h5000, 0, 8'hFF, 0, 1, 0, 0);
    checkOutput("midrst_outs", {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o}, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("midrst_rv", {instr_rvalid_o, data_rvalid_o}, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 64'h6000, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput($sformatf("postrst_gnt%0d", i), instr_gnt_o, 1);
    end
    applyStimulus(1, 64'h6000, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("postrst_blocked", mem_req_o, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput($sformatf("postrst_drain%0d", i), instr_rvalid_o, 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, meaning the address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning the data width; byte-enable width is DATA_WIDTH/8.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the depth of the response-ID FIFO; legal range is 1..8.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports in this order:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
REQ-005 SHALL provide the instruction requester ports:
- instr_req_i  in  1  request
- instr_addr_i  in  ADDR_WIDTH  address
- instr_gnt_o  out  1  grant
- instr_rvalid_o  out  1  response valid
- instr_rdata_o  out  DATA_WIDTH  response data
REQ-006 SHALL provide the data requester ports:
- data_req_i  in  1  request
- data_addr_i  in  ADDR_WIDTH  address
- data_we_i  in  1  write enable
- data_be_i  in  DATA_WIDTH/8  byte enable
- data_wdata_i  in  DATA_WIDTH  write data
- data_gnt_o  out  1  grant
- data_rvalid_o  out  1  response valid
- data_rdata_o  out  DATA_WIDTH  response data
REQ-007 SHALL provide the memory-side ports:
- mem_req_o  out  1  request
- mem_addr_o  out  ADDR_WIDTH  address
- mem_we_o  out  1  write enable
- mem_be_o  out  DATA_WIDTH/8  byte enable
- mem_wdata_o  out  DATA_WIDTH  write data
- mem_gnt_i  in  1  grant
- mem_rvalid_i  in  1  response valid
- mem_rdata_i  in  DATA_WIDTH  response data

Function
REQ-008 SHALL drive mem_req_o together with the selected requester's address, we, be and wdata combinationally in the same cycle; an instruction request drives mem_we_o=0 and mem_be_o all ones.
REQ-009 SHALL issue a request only when the ID FIFO is not full, or when it is full and a pop happens in the same cycle.
REQ-010 SHALL complete a transfer on mem_req_o && mem_gnt_i, assert exactly one of instr_gnt_o/data_gnt_o in that cycle, and push the requester ID (0=instr, 1=data) into the FIFO.
REQ-011 SHALL hold its selection (state LOCKED) while mem_req_o=1 && mem_gnt_i=0, so that the selected request is not switched before it is granted; it SHALL return to IDLE on grant.
REQ-012 SHALL arbitrate in IDLE when both requesters are active according to the configured policy (REQ-020).
REQ-013 SHALL, on mem_rvalid_i, pop the FIFO head and assert the matching *_rvalid_o in the same cycle; writes also receive an rvalid.
REQ-014 SHALL route mem_rdata_i to both *_rdata_o; the data is meaningful only when the matching rvalid is asserted.
REQ-015 SHALL treat mem_rvalid_i with an empty FIFO as an error: the response is dropped, both rvalids stay 0, and a simulation assertion fires.
REQ-016 SHALL support a simultaneous push and pop when the FIFO is full; the occupancy count stays unchanged.
REQ-017 SHALL wrap the FIFO read and write pointers modulo MAX_OUTSTANDING.

Reset
REQ-018 SHALL, while rst_i=1, clear the FIFO (empty), set the state to IDLE and set the RR pointer to instr, and drive all *_gnt_o, *_rvalid_o and mem_req_o to 0.
REQ-019 SHALL discard outstanding responses on a reset mid-operation; memory responses arriving after reset are handled per REQ-015.

Configuration
REQ-020 SHALL implement round-robin arbitration when MEM_ARB_RR_EN is defined: the requester granted last loses the next tie, and the pointer updates only on grant.
REQ-021 SHALL implement fixed priority with data > instr when MEM_ARB_RR_EN is undefined; the RR pointer SHALL not exist in that build.

Structure
REQ-022 SHALL place the requester-ID enum (ARB_INSTR, ARB_DATA) and the FSM state enum (IDLE, LOCKED) in the shared package core_mem_pkg.
REQ-023 SHALL implement the ID FIFO as a sub-module named arb_id_fifo (parameter DEPTH; ports push, pop, data, full, empty).

Verification
REQ-024 SHALL cover: instr-only request of addr 0x8000_0000, with mem_gnt_i=1 and mem_rvalid_i=1 one cycle later -> instr_gnt_o=1 in cycle 0 and instr_rvalid_o=1 in cycle 1.
REQ-025 SHALL cover: both requesters active for 4 cycles with MEM_ARB_RR_EN defined -> grants alternate I,D,I,D; without the macro -> D,D,D,D.
REQ-026 SHALL cover: data request held with mem_gnt_i=0 for 3 cycles while instr requests arrive -> mem_addr_o stays the data address until granted.
REQ-027 SHALL cover: MAX_OUTSTANDING=2 with no mem_rvalid_i for 2 grants -> the third request is not issued; pulsing mem_rvalid_i in the same cycle -> the third is granted.
REQ-028 SHALL cover: rst_i asserted with 2 outstanding requests -> all outputs 0 and a later mem_rvalid_i yields no rvalid plus an assertion.
REQ-029 SHALL cover: a data write of be=0x0F -> mem_be_o=0x0F, mem_we_o=1, and data_rvalid_o is returned on the response.
